// File: rtl/lock_acquire_ctrl_if.sv
// Handshake/settings bundle between the PI loop, the lock sequencer and the DAC.
// master drives settings and loop signals; slave is the sequencer.
interface lock_acquire_ctrl_if #(
  parameter int DATA_WIDTH = 14,
  parameter int CNT_WIDTH  = 24
);
  logic                         enable;
  logic                         relock_en;
  logic signed [DATA_WIDTH-1:0] error;
  logic signed [DATA_WIDTH-1:0] pid_output;
  logic signed [DATA_WIDTH-1:0] sweep_min;
  logic signed [DATA_WIDTH-1:0] sweep_max;
  logic        [DATA_WIDTH-1:0] sweep_step;
  logic        [CNT_WIDTH-1:0]  sweep_div;
  logic        [DATA_WIDTH-1:0] lock_thresh;
  logic        [CNT_WIDTH-1:0]  lock_time;
  logic        [CNT_WIDTH-1:0]  unlock_time;
  logic signed [DATA_WIDTH-1:0] dac_out;
  logic                         pid_rst;
  logic signed [DATA_WIDTH-1:0] i_term_reset;
  logic        [1:0]            state;
  logic                         locked;
  logic                         lock_lost;

  modport master (
    output enable, relock_en, error, pid_output, sweep_min, sweep_max, sweep_step,
           sweep_div, lock_thresh, lock_time, unlock_time,
    input  dac_out, pid_rst, i_term_reset, state, locked, lock_lost
  );

  modport slave (
    input  enable, relock_en, error, pid_output, sweep_min, sweep_max, sweep_step,
           sweep_div, lock_thresh, lock_time, unlock_time,
    output dac_out, pid_rst, i_term_reset, state, locked, lock_lost
  );
endinterface

// File: rtl/lock_acquire_ctrl.sv
// Lock acquisition sequencer: triangle sweep, capture, lock qualification and relock.
// Optional macro LOCK_RAIL_DETECT_EN treats a railed PI output as out of window.
module lock_acquire_ctrl #(
  parameter int DATA_WIDTH = 14,
  parameter int CNT_WIDTH  = 24
) (
  input logic                clk,
  input logic                rst,
  lock_acquire_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, SWEEP = 2'd1, CATCH = 2'd2, LOCKED = 2'd3} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t                       st;
  logic signed [DATA_WIDTH-1:0] ramp, dac_r, iterm_r;
  logic                         dir_up, pid_rst_r, locked_r, lost_r;
  logic        [CNT_WIDTH-1:0]  div_cnt, in_cnt, out_cnt;

  logic signed [DATA_WIDTH:0]   err_ext, ramp_ext, step_ext, min_ext, max_ext, step_res;
  logic        [DATA_WIDTH:0]   abs_err;
  logic                         in_win, div_wrap, dir_next, loss;
  logic signed [DATA_WIDTH-1:0] ramp_next, relock_ramp;
  logic        [CNT_WIDTH-1:0]  in_next, out_next;

`ifdef LOCK_RAIL_DETECT_EN
  localparam logic signed [DATA_WIDTH-1:0] RAIL_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] RAIL_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
`endif

  // |error| needs one extra bit so the most negative code does not wrap.
  always_comb begin
    err_ext = {bus.error[DATA_WIDTH-1], bus.error};
    abs_err = err_ext[DATA_WIDTH] ? -err_ext : err_ext;
    in_win  = abs_err <= {1'b0, bus.lock_thresh};
`ifdef LOCK_RAIL_DETECT_EN
    if ((st == CATCH || st == LOCKED) &&
        (bus.pid_output == RAIL_POS || bus.pid_output == RAIL_NEG))
      in_win = 1'b0;
`endif
  end

  always_comb begin
    in_next  = !in_win ? '0 : (in_cnt == CNT_MAX ? in_cnt : in_cnt + 1'b1);
    out_next = in_win ? '0 : (out_cnt == CNT_MAX ? out_cnt : out_cnt + 1'b1);
    loss     = !in_win && (out_next >= bus.unlock_time);
    div_wrap = div_cnt >= bus.sweep_div;
  end

  always_comb begin
    ramp_ext  = {ramp[DATA_WIDTH-1], ramp};
    step_ext  = {1'b0, bus.sweep_step};
    min_ext   = {bus.sweep_min[DATA_WIDTH-1], bus.sweep_min};
    max_ext   = {bus.sweep_max[DATA_WIDTH-1], bus.sweep_max};
    step_res  = dir_up ? ramp_ext + step_ext : ramp_ext - step_ext;
    ramp_next = ramp;
    dir_next  = dir_up;
    if (bus.sweep_min >= bus.sweep_max) begin
      ramp_next = bus.sweep_min;
    end else if (bus.sweep_step == '0) begin
      ramp_next = ramp;
    end else if (step_res >= max_ext) begin
      ramp_next = bus.sweep_max;
      dir_next  = 1'b0;
    end else if (step_res <= min_ext) begin
      ramp_next = bus.sweep_min;
      dir_next  = 1'b1;
    end else begin
      ramp_next = step_res[DATA_WIDTH-1:0];
    end
    relock_ramp = dac_r;
    if (dac_r < bus.sweep_min)
      relock_ramp = bus.sweep_min;
    else if (dac_r > bus.sweep_max)
      relock_ramp = bus.sweep_max;
  end

  // Disable shares the reset path: both return every register to its idle value.
  always_ff @(posedge clk) begin
    if (rst || !bus.enable) begin
      st        <= IDLE;
      ramp      <= '0;
      dir_up    <= 1'b1;
      dac_r     <= '0;
      iterm_r   <= '0;
      pid_rst_r <= 1'b1;
      locked_r  <= 1'b0;
      lost_r    <= 1'b0;
      div_cnt   <= '0;
      in_cnt    <= '0;
      out_cnt   <= '0;
    end else begin
      unique case (st)
        IDLE: begin
          st        <= SWEEP;
          ramp      <= bus.sweep_min;
          dir_up    <= 1'b1;
          div_cnt   <= '0;
          dac_r     <= bus.sweep_min;
          iterm_r   <= bus.sweep_min;
          pid_rst_r <= 1'b1;
        end
        SWEEP: begin
          pid_rst_r <= 1'b1;
          locked_r  <= 1'b0;
          if (in_win) begin
            st        <= CATCH;
            pid_rst_r <= 1'b0;
            in_cnt    <= '0;
            out_cnt   <= '0;
          end else if (div_wrap) begin
            ramp    <= ramp_next;
            dir_up  <= dir_next;
            dac_r   <= ramp_next;
            iterm_r <= ramp_next;
            div_cnt <= '0;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        CATCH: begin
          dac_r   <= bus.pid_output;
          in_cnt  <= in_next;
          out_cnt <= out_next;
          if (in_next >= bus.lock_time) begin
            st       <= LOCKED;
            locked_r <= in_win;
          end else if (loss) begin
            st        <= SWEEP;
            pid_rst_r <= 1'b1;
            div_cnt   <= '0;
            dac_r     <= ramp;
            iterm_r   <= ramp;
            in_cnt    <= '0;
            out_cnt   <= '0;
          end
        end
        LOCKED: begin
          dac_r    <= bus.pid_output;
          in_cnt   <= in_next;
          out_cnt  <= out_next;
          locked_r <= in_win;
          if (loss) begin
            lost_r <= 1'b1;
            if (bus.relock_en) begin
              st        <= SWEEP;
              ramp      <= relock_ramp;
              dac_r     <= relock_ramp;
              iterm_r   <= relock_ramp;
              pid_rst_r <= 1'b1;
              div_cnt   <= '0;
              locked_r  <= 1'b0;
              in_cnt    <= '0;
              out_cnt   <= '0;
            end
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign bus.dac_out      = dac_r;
  assign bus.pid_rst      = pid_rst_r;
  assign bus.i_term_reset = iterm_r;
  assign bus.state        = st;
  assign bus.locked       = locked_r;
  assign bus.lock_lost    = lost_r;
endmodule

// File: tb/tb_lock_acquire_ctrl.sv
// Vector-table bench for lock_acquire_ctrl; expected outputs are queued at drive time.
// Rail-detect expectations follow LOCK_RAIL_DETECT_EN.
module tb_lock_acquire_ctrl;
  localparam int DW = 14;
  localparam int CW = 24;

  logic clk = 1'b0;
  logic rst = 1'b1;

  lock_acquire_ctrl_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  lock_acquire_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst; logic en; logic rl; int err; int pid;
    int st; int dac; int it; logic prst; logic lk; logic lost;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   vec_id = 0;

  task automatic addVec(input int n, input logic r, input logic en, input logic rl,
                        input int err, input int pid, input int st, input int dac,
                        input int it, input logic prst, input logic lk, input logic lost);
    vec_t v;
    v.rst = r; v.en = en; v.rl = rl; v.err = err; v.pid = pid;
    v.st = st; v.dac = dac; v.it = it; v.prst = prst; v.lk = lk; v.lost = lost;
    repeat (n) vecs.push_back(v);
  endtask

  task automatic setSettings(input int smin, input int smax, input int step, input int div,
                             input int thresh, input int ltime, input int utime);
    bus.sweep_min   = 14'(smin);
    bus.sweep_max   = 14'(smax);
    bus.sweep_step  = 14'(step);
    bus.sweep_div   = 24'(div);
    bus.lock_thresh = 14'(thresh);
    bus.lock_time   = 24'(ltime);
    bus.unlock_time = 24'(utime);
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    rst            = v.rst;
    bus.enable     = v.en;
    bus.relock_en  = v.rl;
    bus.error      = 14'(v.err);
    bus.pid_output = 14'(v.pid);
    exp_q.push_back(v);
  endtask

  task automatic cmp(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("[TB] FAIL vec %0d %s got %0d want %0d", vec_id, name, got, want);
    end
  endtask

  task automatic checkOutput();
    vec_t e;
    @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL vec %0d scoreboard got empty want entry", vec_id);
      return;
    end
    e = exp_q.pop_front();
    cmp("state", int'(bus.state), e.st);
    cmp("dac_out", int'(bus.dac_out), e.dac);
    cmp("i_term_reset", int'(bus.i_term_reset), e.it);
    cmp("pid_rst", int'(bus.pid_rst), int'(e.prst));
    cmp("locked", int'(bus.locked), int'(e.lk));
    cmp("lock_lost", int'(bus.lock_lost), int'(e.lost));
    vec_id++;
  endtask

  task automatic runVecs();
    vec_t v;
    while (vecs.size() > 0) begin
      v = vecs.pop_front();
      applyStimulus(v);
      checkOutput();
    end
  endtask

  initial begin
    bus.enable = 1'b0; bus.relock_en = 1'b1; bus.error = '0; bus.pid_output = '0;
    setSettings(-100, 100, 50, 3, 10, 8, 4);

    // Sweep, capture at 50 on the way down, lock, lose lock and relock from clamp(123)=100.
    addVec(1, 1, 0, 1,  1000, 123, 0,    0,    0, 1, 0, 0);
    addVec(4, 0, 1, 1,  1000, 123, 1, -100, -100, 1, 0, 0);
    addVec(4, 0, 1, 1,  1000, 123, 1,  -50,  -50, 1, 0, 0);
    addVec(4, 0, 1, 1,  1000, 123, 1,    0,    0, 1, 0, 0);
    addVec(4, 0, 1, 1,  1000, 123, 1,   50,   50, 1, 0, 0);
    addVec(4, 0, 1, 1,  1000, 123, 1,  100,  100, 1, 0, 0);
    addVec(1, 0, 1, 1,  1000, 123, 1,   50,   50, 1, 0, 0);
    addVec(1, 0, 1, 1,     5, 123, 2,   50,   50, 0, 0, 0);
    addVec(7, 0, 1, 1,     3, 123, 2,  123,   50, 0, 0, 0);
    addVec(1, 0, 1, 1,     3, 123, 3,  123,   50, 0, 1, 0);
    addVec(3, 0, 1, 1, -8192, 123, 3,  123,   50, 0, 0, 0);
    addVec(4, 0, 1, 1, -8192, 123, 1,  100,  100, 1, 0, 1);
    addVec(1, 0, 1, 1, -8192, 123, 1,   50,   50, 1, 0, 1);
    addVec(1, 0, 0, 1, -8192, 123, 0,    0,    0, 1, 0, 0);
    // Same loss without relock: stays LOCKED, then disable clears the flag.
    addVec(1, 0, 1, 0,  1000, 123, 1, -100, -100, 1, 0, 0);
    addVec(1, 0, 1, 0,     5, 123, 2, -100, -100, 0, 0, 0);
    addVec(7, 0, 1, 0,     3, 123, 2,  123, -100, 0, 0, 0);
    addVec(1, 0, 1, 0,     3, 123, 3,  123, -100, 0, 1, 0);
    addVec(3, 0, 1, 0, -8192, 123, 3,  123, -100, 0, 0, 0);
    addVec(2, 0, 1, 0, -8192, 123, 3,  123, -100, 0, 0, 1);
    addVec(1, 0, 0, 0, -8192, 123, 0,    0,    0, 1, 0, 0);
    runVecs();

    // Railed PI output while locked with zero error.
    addVec(1, 1, 0, 0, 1000,  123, 0,    0,    0, 1, 0, 0);
    addVec(1, 0, 1, 0, 1000,  123, 1, -100, -100, 1, 0, 0);
    addVec(1, 0, 1, 0,    0,  123, 2, -100, -100, 0, 0, 0);
    addVec(7, 0, 1, 0,    0,  123, 2,  123, -100, 0, 0, 0);
    addVec(1, 0, 1, 0,    0,  123, 3,  123, -100, 0, 1, 0);
`ifdef LOCK_RAIL_DETECT_EN
    addVec(3, 0, 1, 0,    0, 8191, 3, 8191, -100, 0, 0, 0);
    addVec(1, 0, 1, 0,    0, 8191, 3, 8191, -100, 0, 0, 1);
`else
    addVec(4, 0, 1, 0,    0, 8191, 3, 8191, -100, 0, 1, 0);
`endif
    runVecs();

    // Window edges (11 out, -10 in), lock_time=0, then rst while locked.
    setSettings(-100, 100, 50, 3, 10, 0, 4);
    addVec(1, 1, 0, 1, 1000, 123, 0,    0,    0, 1, 0, 0);
    addVec(1, 0, 1, 1, 1000, 123, 1, -100, -100, 1, 0, 0);
    addVec(1, 0, 1, 1,   11, 123, 1, -100, -100, 1, 0, 0);
    addVec(1, 0, 1, 1,  -10, 123, 2, -100, -100, 0, 0, 0);
    addVec(1, 0, 1, 1,  -10, 123, 3,  123, -100, 0, 1, 0);
    addVec(1, 1, 1, 1,  -10, 123, 0,    0,    0, 1, 0, 0);
    runVecs();

    // Degenerate bounds hold the ramp at sweep_min.
    setSettings(30, 10, 50, 0, 10, 8, 4);
    addVec(1, 1, 0, 1, 1000, 0, 0,  0,  0, 1, 0, 0);
    addVec(4, 0, 1, 1, 1000, 0, 1, 30, 30, 1, 0, 0);
    runVecs();

    // Zero step holds the ramp.
    setSettings(-100, 100, 0, 0, 10, 8, 4);
    addVec(1, 1, 0, 1, 1000, 0, 0,    0,    0, 1, 0, 0);
    addVec(4, 0, 1, 1, 1000, 0, 1, -100, -100, 1, 0, 0);
    runVecs();

    // Non-dividing step clamps at both ends and reverses.
    setSettings(-100, 100, 70, 0, 10, 8, 4);
    addVec(1, 1, 0, 1, 1000, 0, 0,    0,    0, 1, 0, 0);
    addVec(1, 0, 1, 1, 1000, 0, 1, -100, -100, 1, 0, 0);
    addVec(1, 0, 1, 1, 1000, 0, 1,  -30,  -30, 1, 0, 0);
    addVec(1, 0, 1, 1, 1000, 0, 1,   40,   40, 1, 0, 0);
    addVec(1, 0, 1, 1, 1000, 0, 1,  100,  100, 1, 0, 0);
    addVec(1, 0, 1, 1, 1000, 0, 1,   30,   30, 1, 0, 0);
    addVec(1, 0, 1, 1, 1000, 0, 1,  -40,  -40, 1, 0, 0);
    addVec(1, 0, 1, 1, 1000, 0, 1, -100, -100, 1, 0, 0);
    addVec(1, 0, 1, 1, 1000, 0, 1,  -30,  -30, 1, 0, 0);
    runVecs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
